spu_op_sched: RTL

Command scheduler for the SPU engines: LayerNorm, Softmax and GELU.
- Accepts layer descriptors from the top-level controller into a small queue.
- Drives the shared configuration bus (matrix dims, base addresses, align strides, LN scaling) to the selected engine and issues its start pulse.
- Waits for the engine's end pulse, then reports completion and error status.
- Does not mux the lbuf port; that is owned by the lbuf mux and steered by `active_op`.

---
 rtl/spu_sched_pkg.sv | 42 ++++
 rtl/spu_cmd_fifo.sv | 71 +++++++
 rtl/spu_op_sched.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/spu_sched_pkg.sv
// Shared definitions for the SPU operation scheduler: op codes, FSM state
// encoding, completion error codes and the packed command descriptor layout.
package spu_sched_pkg;

    // Engine selection codes carried in a descriptor
    localparam logic [1:0] OP_LN   = 2'd0;
    localparam logic [1:0] OP_SM   = 2'd1;
    localparam logic [1:0] OP_GELU = 2'd2;
    localparam logic [1:0] OP_ILL  = 2'd3;

    // Scheduler FSM encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_BUSY  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Completion status reported alongside done_valid
    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_SIZE    = 2'b11;

    // Fixed-width part of a descriptor; the address-width fields are
    // appended below it so the descriptor can follow ADDR_WIDTH
    typedef struct packed {
        logic [1:0] op;
        logic [3:0] tag;
        logic [3:0] ln_shift;
        logic [6:0] ln_div_m;
        logic [4:0] ln_div_e;
    } spu_ctl_t;

    localparam int CTL_WIDTH = $bits(spu_ctl_t);

    // Full descriptor: control bits plus six address-width fields
    // (matrix_y, matrix_x, im_base, om_base, ifm_align, ofm_align)
    function automatic int desc_width(input int addr_width);
        return CTL_WIDTH + 6 * addr_width;
    endfunction

endpackage

// File: rtl/spu_cmd_fifo.sv
// Synchronous command queue of packed descriptors. Head is presented
// combinationally (first-word fall-through); full/empty come from an
// occupancy count and the push-side ready is registered from that count.
module spu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             core_clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok  = push_valid && push_ready;
    assign pop_ok   = pop && (count != '0);
    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);

    // Occupancy after this cycle; a simultaneous push and pop cancel out
    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_next = count - 1'b1;
        end
    end

    // Descriptor storage, written at the tail
    always_ff @(posedge core_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, count and a ready that only reflects the settled count
    always_ff @(posedge core_clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            push_ready <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count      <= count_next;
            push_ready <= (count_next != FULL_CNT);
        end
    end

endmodule

// File: rtl/spu_op_sched.sv
// Command scheduler for the LayerNorm, Softmax and GELU engines. Queues
// descriptors, drives the shared configuration bus, issues the start pulse,
// waits for the matching end pulse (with an optional watchdog) and reports
// completion status per command.
module spu_op_sched
    import spu_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4,
    parameter int TO_WIDTH   = 20
) (
    input  logic                  core_clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [3:0]            cmd_tag,
    input  logic [ADDR_WIDTH-1:0] cmd_matrix_y,
    input  logic [ADDR_WIDTH-1:0] cmd_matrix_x,
    input  logic [ADDR_WIDTH-1:0] cmd_im_base,
    input  logic [ADDR_WIDTH-1:0] cmd_om_base,
    input  logic [ADDR_WIDTH-1:0] cmd_ifm_align,
    input  logic [ADDR_WIDTH-1:0] cmd_ofm_align,
    input  logic [3:0]            cmd_ln_shift,
    input  logic [6:0]            cmd_ln_div_m,
    input  logic [4:0]            cmd_ln_div_e,
    input  logic [TO_WIDTH-1:0]   timeout_limit,
    output logic [ADDR_WIDTH-1:0] spu_matrix_y,
    output logic [ADDR_WIDTH-1:0] spu_matrix_x,
    output logic [ADDR_WIDTH-1:0] im_base_addr,
    output logic [ADDR_WIDTH-1:0] om_base_addr,
    output logic [ADDR_WIDTH-1:0] ifm_addr_align,
    output logic [ADDR_WIDTH-1:0] ofm_addr_align,
    output logic [3:0]            ln_shift_output,
    output logic [6:0]            ln_div_m,
    output logic [4:0]            ln_div_e,
    output logic                  ln_start,
    output logic                  sm_start,
    output logic                  gelu_start,
    input  logic                  ln_end,
    input  logic                  sm_end,
    input  logic                  gelu_end,
    output logic [1:0]            active_op,
    output logic                  busy,
    output logic                  done_valid,
    output logic [3:0]            done_tag,
    output logic [1:0]            done_err,
    output logic                  spurious_end
);

    localparam int DESC_WIDTH = desc_width(ADDR_WIDTH);

    logic [2:0]            state;
    logic [2:0]            state_next;
    spu_ctl_t              push_ctl;
    spu_ctl_t              head_ctl;
    logic [DESC_WIDTH-1:0] push_desc;
    logic [DESC_WIDTH-1:0] head_desc;
    logic [ADDR_WIDTH-1:0] head_y;
    logic [ADDR_WIDTH-1:0] head_x;
    logic [ADDR_WIDTH-1:0] head_im;
    logic [ADDR_WIDTH-1:0] head_om;
    logic [ADDR_WIDTH-1:0] head_ifa;
    logic [ADDR_WIDTH-1:0] head_ofa;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [1:0]            load_err;
    logic                  sel_end;
    logic                  other_end;
    logic                  any_end;
    logic                  wd_hit;
    logic [TO_WIDTH-1:0]   wd_cnt;

    assign push_ctl = '{op: cmd_op, tag: cmd_tag, ln_shift: cmd_ln_shift,
                        ln_div_m: cmd_ln_div_m, ln_div_e: cmd_ln_div_e};
    assign push_desc = {push_ctl, cmd_matrix_y, cmd_matrix_x, cmd_im_base,
                        cmd_om_base, cmd_ifm_align, cmd_ofm_align};
    assign {head_ctl, head_y, head_x, head_im, head_om, head_ifa, head_ofa} = head_desc;

    // The head is consumed exactly in the LOAD cycle
    assign fifo_pop = (state == ST_LOAD);

    spu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DESC_WIDTH)
    ) u_cmd_fifo (
        .core_clk   (core_clk),
        .rst        (rst),
        .push_valid (cmd_valid),
        .push_ready (cmd_ready),
        .push_data  (push_desc),
        .pop        (fifo_pop),
        .pop_data   (head_desc),
        .empty      (fifo_empty)
    );

    // Classify the head descriptor; LN needs at least one word per row (x >> 2)
    always_comb begin
        load_err = ERR_OK;
        if (head_ctl.op == OP_ILL) begin
            load_err = ERR_ILLEGAL;
        end else if ((head_y == '0) || (head_x < ADDR_WIDTH'(4))) begin
            load_err = ERR_SIZE;
        end
    end

    // Split end pulses into the one from the running engine and the rest
    always_comb begin
        sel_end   = 1'b0;
        other_end = 1'b0;
        case (active_op)
            OP_LN: begin
                sel_end   = ln_end;
                other_end = sm_end | gelu_end;
            end
            OP_SM: begin
                sel_end   = sm_end;
                other_end = ln_end | gelu_end;
            end
            OP_GELU: begin
                sel_end   = gelu_end;
                other_end = ln_end | sm_end;
            end
            default: begin
                other_end = ln_end | sm_end | gelu_end;
            end
        endcase
    end

    assign any_end = ln_end | sm_end | gelu_end;
    assign wd_hit  = (timeout_limit != '0) && (wd_cnt == (timeout_limit - 1'b1));

    // Next-state logic; an end pulse on the timeout cycle still counts as success
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (!fifo_empty) state_next = ST_LOAD;
            ST_LOAD:  state_next = (load_err != ERR_OK) ? ST_DONE : ST_START;
            ST_START: state_next = ST_BUSY;
            ST_BUSY:  if (sel_end || wd_hit) state_next = ST_DONE;
            ST_DONE:  state_next = fifo_empty ? ST_IDLE : ST_LOAD;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State, config bus, watchdog, completion status and sticky spurious flag
    always_ff @(posedge core_clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            spu_matrix_y    <= '0;
            spu_matrix_x    <= '0;
            im_base_addr    <= '0;
            om_base_addr    <= '0;
            ifm_addr_align  <= '0;
            ofm_addr_align  <= '0;
            ln_shift_output <= '0;
            ln_div_m        <= '0;
            ln_div_e        <= '0;
            active_op       <= '0;
            done_tag        <= '0;
            done_err        <= '0;
            wd_cnt          <= '0;
            spurious_end    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_LOAD) begin
                spu_matrix_y    <= head_y;
                spu_matrix_x    <= head_x;
                im_base_addr    <= head_im;
                om_base_addr    <= head_om;
                ifm_addr_align  <= head_ifa;
                ofm_addr_align  <= head_ofa;
                ln_shift_output <= head_ctl.ln_shift;
                ln_div_m        <= head_ctl.ln_div_m;
                ln_div_e        <= head_ctl.ln_div_e;
                active_op       <= head_ctl.op;
                done_tag        <= head_ctl.tag;
                done_err        <= load_err;
            end
            if (state == ST_START) begin
                wd_cnt <= '0;
            end
            if (state == ST_BUSY) begin
                if (sel_end) begin
                    done_err <= ERR_OK;
                end else if (wd_hit) begin
                    done_err <= ERR_TIMEOUT;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end
            if ((state == ST_BUSY) ? other_end : any_end) begin
                spurious_end <= 1'b1;
            end
        end
    end

    assign ln_start   = (state == ST_START) && (active_op == OP_LN);
    assign sm_start   = (state == ST_START) && (active_op == OP_SM);
    assign gelu_start = (state == ST_START) && (active_op == OP_GELU);
    assign busy       = (state != ST_IDLE);
    assign done_valid = (state == ST_DONE);

endmodule
